// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller for the RV32 core. Produces the
//               per-register stall/flush vectors and the PC redirect from
//               load-use hazards (multi-cycle bubble sequence), data-memory
//               wait states and taken branches resolved in EXE. Keeps
//               saturating stall and flush performance counters.
// Ports       : clk_i           - clock, rising edge
//               rst_i           - asynchronous reset, active-low
//               load_hazard_i   - load-use hazard from forwarding unit
//               mem_busy_i      - data memory not ready this cycle
//               branch_taken_i  - taken branch/jump resolved in EXE
//               branch_target_i - redirect target
//               clr_cnt_i       - synchronous clear of both counters
//               stall_o         - bit k holds pipeline register k (0 = PC)
//               flush_o         - bit k loads a bubble into register k
//               pc_redirect_o   - PC loads pc_target_o next edge
//               pc_target_o     - redirect target, 0 when not redirecting
//               stall_cnt_o     - cycles with any stall bit set
//               flush_cnt_o     - cycles with a PC redirect
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
    parameter int NUM_STAGES        = 5,
    parameter int IDEX_IDX          = 2,
    parameter int EXMEM_IDX         = 3,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int ADDR_WIDTH        = 32,
    parameter int CNT_WIDTH         = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  load_hazard_i,
    input  logic                  mem_busy_i,
    input  logic                  branch_taken_i,
    input  logic [ADDR_WIDTH-1:0] branch_target_i,
    input  logic                  clr_cnt_i,
    output logic [NUM_STAGES-1:0] stall_o,
    output logic [NUM_STAGES-1:0] flush_o,
    output logic                  pc_redirect_o,
    output logic [ADDR_WIDTH-1:0] pc_target_o,
    output logic [CNT_WIDTH-1:0]  stall_cnt_o,
    output logic [CNT_WIDTH-1:0]  flush_cnt_o
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_LSTALL = 1'b1;

    localparam logic [3:0] C_REM_INIT = 4'(LOAD_STALL_CYCLES - 1);

    logic [0:0]            r_state;
    logic [3:0]            r_rem;
    logic [CNT_WIDTH-1:0]  r_stall_cnt;
    logic [CNT_WIDTH-1:0]  r_flush_cnt;

    logic                  w_memw;
    logic                  w_brch;
    logic                  w_ldst;
    logic [NUM_STAGES-1:0] w_stall;
    logic [NUM_STAGES-1:0] w_flush;

    // Priority MEMW > BRCH > LDST. While in LSTALL the load pattern is driven
    // regardless of load_hazard_i; a branch alongside a load hazard wins
    // because the load-use instruction is flushed anyway.
    assign w_memw = mem_busy_i;
    assign w_brch = !mem_busy_i && branch_taken_i;
    assign w_ldst = !mem_busy_i && !branch_taken_i &&
                    ((r_state == S_LSTALL) || load_hazard_i);

    always_comb begin
        w_stall = '0;
        w_flush = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (w_memw && (k <= EXMEM_IDX))             w_stall[k] = 1'b1;
            if (w_memw && (k == EXMEM_IDX + 1))         w_flush[k] = 1'b1;
            if (w_brch && (k >= 1) && (k <= IDEX_IDX))  w_flush[k] = 1'b1;
            if (w_ldst && (k < IDEX_IDX))               w_stall[k] = 1'b1;
            if (w_ldst && (k == IDEX_IDX))              w_flush[k] = 1'b1;
        end
    end

    // Outputs are zero-latency from state and inputs, and held at 0 for as
    // long as reset is asserted.
    assign stall_o       = rst_i ? w_stall : '0;
    assign flush_o       = rst_i ? w_flush : '0;
    assign pc_redirect_o = rst_i && w_brch;
    assign pc_target_o   = (rst_i && w_brch) ? branch_target_i : '0;
    assign stall_cnt_o   = rst_i ? r_stall_cnt : '0;
    assign flush_cnt_o   = rst_i ? r_flush_cnt : '0;

    // Load-stall sequencer. rem counts the bubbles still owed after the
    // current one; memory wait cycles freeze it so exactly
    // LOAD_STALL_CYCLES non-busy bubbles are issued.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
            r_rem   <= 4'd0;
        end else if (r_state == S_IDLE) begin
            if (w_ldst && (LOAD_STALL_CYCLES > 1)) begin
                r_state <= S_LSTALL;
                r_rem   <= C_REM_INIT;
            end
        end else begin
            if (w_memw) begin
                r_state <= r_state;
                r_rem   <= r_rem;
            end else if (w_brch || (r_rem <= 4'd1)) begin
                r_state <= S_IDLE;
                r_rem   <= 4'd0;
            end else begin
                r_rem   <= r_rem - 4'd1;
            end
        end
    end

    // Saturating performance counters; clear beats a same-cycle increment.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else if (clr_cnt_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if ((|w_stall) && (r_stall_cnt != {CNT_WIDTH{1'b1}}))
                r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
            if (w_brch && (r_flush_cnt != {CNT_WIDTH{1'b1}}))
                r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire
